// File: rtl/relu_stream_ctrl.sv
// relu_stream_ctrl: streams words from memory, clamps negative lanes to zero
// and writes the rectified words back, counting the clamped lanes.
module relu_stream_ctrl #(
  parameter int DIM    = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      src_base,
  input  logic [ADDR_W-1:0]      dst_base,
  input  logic [ADDR_W:0]        num_words,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [DIM*WIDTH-1:0]   rd_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DIM*WIDTH-1:0]   wr_data,
  output logic [31:0]            neg_count
);

  localparam int CW = $clog2(DIM + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [ADDR_W-1:0]    src;
  logic [ADDR_W-1:0]    dst;
  logic [ADDR_W:0]      nwords;
  logic [ADDR_W:0]      idx;
  logic [ADDR_W-1:0]    widx;
  logic                 rvld;
  logic                 last_rd;
  logic                 accept;
  logic                 wr_load;

  logic [DIM*WIDTH-1:0] rect;
  logic [WIDTH-1:0]     lane;
  logic [CW-1:0]        nclamp;
  logic [32:0]          nsum;
  logic [31:0]          nsat;

  assign last_rd = (idx == nwords - 1'b1);
  assign accept  = (state == IDLE) && start;
  assign wr_load = rvld && !abort
                && ((state == RUN) || (state == DRAIN));

  // Next-state selection; abort wins over any progress in RUN/DRAIN.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          nstate = (num_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          nstate = IDLE;
        end else if (last_rd) begin
          nstate = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          nstate = IDLE;
        end else if (!rvld) begin
          nstate = DONE;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Moore outputs; read address is forced to zero outside RUN.
  always_comb begin
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == DONE);
    rd_en   = (state == RUN);
    rd_addr = '0;
    if (state == RUN) begin
      rd_addr = src + idx[ADDR_W-1:0];
    end
  end

  // Per-lane rectification of the returning read word and clamp count.
  always_comb begin
    rect   = '0;
    lane   = '0;
    nclamp = '0;
    for (int i = 0; i < DIM; i++) begin
      lane = rd_data[i*WIDTH +: WIDTH];
      if (lane[WIDTH-1]) begin
        rect[i*WIDTH +: WIDTH] = '0;
        nclamp = nclamp + CW'(1);
      end else begin
        rect[i*WIDTH +: WIDTH] = lane;
      end
    end
  end

  // Saturating accumulation of clamped lanes.
  always_comb begin
    nsum = {1'b0, neg_count} + 33'(nclamp);
    nsat = nsum[32] ? '1 : nsum[31:0];
  end

  // Job parameters, read index and read-return valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      src    <= '0;
      dst    <= '0;
      nwords <= '0;
      idx    <= '0;
      rvld   <= 1'b0;
    end else begin
      rvld <= (state == RUN) && !abort;
      if (accept) begin
        src    <= src_base;
        dst    <= dst_base;
        nwords <= num_words;
        idx    <= '0;
      end else if (state == RUN) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Write stage: registers the rectified word and updates the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      widx      <= '0;
      neg_count <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        widx      <= '0;
        neg_count <= '0;
      end else if (wr_load) begin
        wr_en     <= 1'b1;
        wr_addr   <= dst + widx;
        wr_data   <= rect;
        widx      <= widx + 1'b1;
        neg_count <= nsat;
      end
    end
  end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb_relu_stream_ctrl: scoreboard bench with a memory model and a
// lane-level reference for the rectifying stream controller.
module tb_relu_stream_ctrl;

  localparam int DIM = 4;
  localparam int WIDTH = 16;
  localparam int AW = 10;
  localparam int DW = DIM * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [31:0]   neg_count;

  always #5 clk = ~clk;

  relu_stream_ctrl #(.DIM(DIM), .WIDTH(WIDTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .num_words(num_words),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .neg_count(neg_count)
  );

  logic [DW-1:0] mem [0:1023];

  always @(posedge clk) begin
    if (rd_en === 1'b1) rd_data <= mem[rd_addr];
    else rd_data <= {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];
  int            exp_neg;

  int e_cyc = 0;
  int mk;
  int rd_n, rd_first, rd_last;
  int wr_n, wr_first, wr_last;
  int done_n, done_k, busy_n;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    mk = cyc - e_cyc;
    if (rd_en === 1'b1) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
      rd_n++;
      if (rd_n == 1) rd_first = mk;
      rd_last = mk;
    end
    if (wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(w.a));
        chk("wr_data", wr_data, w.d);
      end
      wr_n++;
      if (wr_n == 1) wr_first = mk;
      wr_last = mk;
    end
    if (done === 1'b1) begin
      done_n++;
      done_k = mk;
    end
    if (busy === 1'b1) busy_n++;
  end

  function automatic logic [DW-1:0] relu_word(input logic [DW-1:0] w,
                                              output int cnt);
    logic [DW-1:0] r;
    logic signed [WIDTH-1:0] v;
    r = '0;
    cnt = 0;
    for (int l = 0; l < DIM; l++) begin
      v = w[l*WIDTH +: WIDTH];
      if (v < 0) cnt++;
      else r[l*WIDTH +: WIDTH] = v;
    end
    return r;
  endfunction

  task automatic plan(input int src, input int dst, input int nrd,
                      input int nwr);
    wr_t w;
    int  c;
    exp_neg = 0;
    for (int i = 0; i < nrd; i++) exp_rd.push_back(AW'((src + i) % 1024));
    for (int i = 0; i < nwr; i++) begin
      w.a = AW'((dst + i) % 1024);
      w.d = relu_word(mem[(src + i) % 1024], c);
      exp_neg += c;
      exp_wr.push_back(w);
    end
  endtask

  task automatic clear_stats();
    rd_n = 0; rd_first = -1; rd_last = -1;
    wr_n = 0; wr_first = -1; wr_last = -1;
    done_n = 0; done_k = -1; busy_n = 0;
  endtask

  task automatic issue(input int src, input int dst, input int n);
    src_base = AW'(src);
    dst_base = AW'(dst);
    num_words = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e_cyc = cyc;
  endtask

  task automatic run_job(input int src, input int dst, input int n);
    int t;
    clear_stats();
    plan(src, dst, n, n);
    issue(src, dst, n);
    t = 0;
    while (done_n == 0 && t < n + 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_n, 1);
    chk("done_cycle", done_k, n + 2 * (n > 0 ? 1 : 0));
    chk("rd_count", rd_n, n);
    chk("wr_count", wr_n, n);
    chk("busy_cycles", busy_n, n > 0 ? n + 2 : 0);
    if (n > 0) begin
      chk("rd_first", rd_first, 0);
      chk("rd_last", rd_last, n - 1);
      chk("wr_first", wr_first, 2);
      chk("wr_last", wr_last, n + 1);
    end
    chk("neg_count", neg_count, exp_neg);
    chk("rd_queue_left", exp_rd.size(), 0);
    chk("wr_queue_left", exp_wr.size(), 0);
  endtask

  initial begin
    int s, d, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; num_words = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_neg_count", neg_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mem[16] = {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
    mem[17] = {16'h0005, 16'h7FFF, 16'h8000, 16'h0000};
    mem[18] = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    run_job(16, 256, 3);
    chk("directed_neg7", neg_count, 7);

    run_job(5, 9, 0);
    chk("zero_len_neg", neg_count, 0);

    run_job(1022, 1023, 3);

    for (int j = 0; j < 6; j++) begin
      s = $urandom_range(0, 1023);
      d = $urandom_range(0, 1023);
      n = $urandom_range(1, 12);
      run_job(s, d, n);
    end

    clear_stats();
    s = $urandom_range(0, 1023);
    d = $urandom_range(0, 1023);
    plan(s, d, 5, 3);
    issue(s, d, 8);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_wr_en", wr_en, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_done", done_n, 0);
    chk("abort_rd_n", rd_n, 5);
    chk("abort_rd_last", rd_last, 4);
    chk("abort_wr_n", wr_n, 3);
    chk("abort_wr_first", wr_first, 2);
    chk("abort_wr_last", wr_last, 4);
    chk("abort_neg", neg_count, exp_neg);
    chk("abort_rdq", exp_rd.size(), 0);
    chk("abort_wrq", exp_wr.size(), 0);

    run_job($urandom_range(0, 1023), $urandom_range(0, 1023), 4);

    clear_stats();
    s = $urandom_range(0, 1023);
    d = $urandom_range(0, 1023);
    plan(s, d, 3, 1);
    issue(s, d, 6);
    @(posedge clk);
    #1;
    start = 1'b1;
    src_base = AW'(s + 100);
    dst_base = AW'(d + 200);
    num_words = 11'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_wr_addr", wr_addr, 0);
    chk("rst_mid_wr_data", wr_data, 0);
    chk("rst_mid_neg", neg_count, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_n, 0);
    chk("rst_mid_rd_n", rd_n, 3);
    chk("rst_mid_wr_n", wr_n, 1);
    chk("rst_mid_rdq", exp_rd.size(), 0);
    chk("rst_mid_wrq", exp_wr.size(), 0);

    run_job($urandom_range(0, 1023), $urandom_range(0, 1023), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_stream_ctrl.md
RELU_STREAM_CTRL -- requirements
Module: relu_stream_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 4, lanes per memory word.
REQ-002 SHALL have parameter WIDTH, default 16, signed lane width in bits.
REQ-003 SHALL have parameter ADDR_W, default 10, word address width.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  job request, sampled only in IDLE.
REQ-007 SHALL have port abort  in  1  cancel the active job.
REQ-008 SHALL have port src_base  in  ADDR_W  first source word address, latched at start.
REQ-009 SHALL have port dst_base  in  ADDR_W  first destination word address, latched at start.
REQ-010 SHALL have port num_words  in  ADDR_W+1  job length in words, latched at start.
REQ-011 SHALL have port busy  out  1  job in progress.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rd_en  out  1  memory read strobe.
REQ-014 SHALL have port rd_addr  out  ADDR_W  read word address.
REQ-015 SHALL have port rd_data  in  DIM*WIDTH  read data, valid exactly one cycle after rd_en; lane i at bits [i*WIDTH +: WIDTH].
REQ-016 SHALL have port wr_en  out  1  memory write strobe.
REQ-017 SHALL have port wr_addr  out  ADDR_W  write word address.
REQ-018 SHALL have port wr_data  out  DIM*WIDTH  rectified word, same lane packing.
REQ-019 SHALL have port neg_count  out  32  number of lanes clamped to zero in the current/last job.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-021 SHALL, in IDLE with start=1 and num_words>0, latch src_base/dst_base/num_words, clear neg_count, enter RUN.
REQ-022 SHALL, in IDLE with start=1 and num_words=0, enter DONE directly; no rd_en/wr_en.
REQ-023 SHALL, in RUN, assert rd_en every cycle with rd_addr = src_base + idx (mod 2^ADDR_W), idx 0..num_words-1, then enter DRAIN after the cycle issuing idx=num_words-1.
REQ-024 SHALL register rd_data one cycle after each read, rectifying per lane: negative (MSB=1) -> 0, else unchanged; -0 boundary: value 0 passes as 0, most-negative value -> 0.
REQ-025 SHALL assert wr_en two cycles after the matching rd_en with wr_addr = dst_base + idx (mod 2^ADDR_W) and the registered rectified word; writes in read order, one per cycle, no gaps.
REQ-026 SHALL add the number of clamped lanes of each written word to neg_count in the wr_en cycle's edge; saturate at 2^32-1; hold value after DONE until next accepted start.
REQ-027 SHALL remain in DRAIN until the last write has been issued, then enter DONE.
REQ-028 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-029 SHALL drive busy=1 in RUN and DRAIN only; busy=0 in IDLE and DONE.
REQ-030 SHALL ignore start while not in IDLE; latched parameters unchanged.
REQ-031 SHALL, on abort=1 in RUN or DRAIN, go to IDLE next edge, deassert rd_en/wr_en from next cycle, discard in-flight data, no done pulse; neg_count holds partial value.
REQ-032 SHALL ignore abort in IDLE and DONE; abort has priority over start in the same cycle.
REQ-033 SHALL give timing: start sampled at edge E -> rd_en cycles E+0..E+N-1, wr_en cycles E+2..E+N+1, done cycle E+N+2 (cycle E+k = k cycles after E).

Reset
REQ-034 SHALL, while rst=1 at a rising edge, enter IDLE and clear busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, neg_count and pipeline valids, overriding start and abort.
REQ-035 SHALL, on rst mid-job, produce no further rd_en/wr_en and no done pulse.

Verification
REQ-036 SHALL cover: DIM=4, src=0x010, dst=0x100, N=3, words {1,-2,3,-4},{0,-32768,32767,5},{-1,-1,-1,-1} -> writes {1,0,3,0},{0,0,32767,5},{0,0,0,0} at 0x100..0x102, done at E+5, neg_count=7.
REQ-037 SHALL cover: start with num_words=0 -> done at E+0, busy never 1, no rd_en/wr_en, neg_count=0.
REQ-038 SHALL cover: src=0x3FE, dst=0x3FF, N=3 -> rd_addr 0x3FE,0x3FF,0x000; wr_addr 0x3FF,0x000,0x001.
REQ-039 SHALL cover: N=8, abort at E+4 -> rd_en cycles E+0..E+4 only, wr_en E+2..E+4 only, no done, busy=0 from E+5.
REQ-040 SHALL cover: start pulsed again at E+1 with different bases -> ignored; all addresses from first job; rst at E+2 -> IDLE, outputs cleared, no done.
